// File: rtl/pkt_match_pkg.sv
// Shared types and helpers for the AXI-Stream packet matcher: monitor FSM
// state encoding and a width-generic saturating increment.
package pkt_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_PKT   = 2'd1,
    ST_OVERFLOW = 2'd2
  } mon_state_e;

  localparam int SAT_W = 64;

  // Increment v as a w-bit counter, holding at all-ones of that width.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
    logic [SAT_W-1:0] top;
    top = '1;
    if (w < SAT_W) top = top >> (SAT_W - w);
    return (v >= top) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/beat_cmp.sv
// Masked single-beat compare: data must agree on every masked bit, and every
// byte that carries a masked bit must be marked valid by tkeep.
module beat_cmp #(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0]   tdata,
  input  logic [DATA_WIDTH/8-1:0] tkeep,
  input  logic [DATA_WIDTH-1:0]   exp_data,
  input  logic [DATA_WIDTH-1:0]   exp_mask,
  output logic                    match
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] diff;
  logic [NB-1:0]         byte_ok;

  assign diff = (tdata ^ exp_data) & exp_mask;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign byte_ok[b] = ~(|diff[b*8 +: 8]) & (~(|exp_mask[b*8 +: 8]) | tkeep[b]);
  end

  assign match = &byte_ok;

endmodule

// File: rtl/axis_pkt_matcher.sv
// Passive AXI-Stream packet matcher: compares each packet against a table of
// multi-beat masked patterns, pulsing hit and counting hits and packets.
// Optional per-pattern watchdog enabled by AXIS_PKT_MATCHER_TIMEOUT_EN.
module axis_pkt_matcher
  import pkt_match_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int NUM_PATTERNS   = 2,
  parameter int MAX_BEATS      = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int IW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           arm,
  input  logic                           cfg_wr,
  input  logic [IW-1:0]                  cfg_idx,
  input  logic [BW-1:0]                  cfg_beat,
  input  logic [BW:0]                    cfg_len,
  input  logic [DATA_WIDTH-1:0]          cfg_data,
  input  logic [DATA_WIDTH-1:0]          cfg_mask,
  input  logic [DATA_WIDTH-1:0]          mon_tdata,
  input  logic [DATA_WIDTH/8-1:0]        mon_tkeep,
  input  logic                           mon_tvalid,
  input  logic                           mon_tready,
  input  logic                           mon_tlast,
  output logic [NUM_PATTERNS-1:0]        hit,
  output logic [NUM_PATTERNS*CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0]           pkt_cnt,
  output logic [NUM_PATTERNS-1:0]        timeout
);

  localparam logic [BW:0] MAX_IDX = (BW+1)'(MAX_BEATS);

  logic [DATA_WIDTH-1:0] tbl_data [NUM_PATTERNS][MAX_BEATS];
  logic [DATA_WIDTH-1:0] tbl_mask [NUM_PATTERNS][MAX_BEATS];
  logic [BW:0]           tbl_len  [NUM_PATTERNS];

  mon_state_e state_q, state_nxt;
  logic       pkt_start, in_ovf, in_range;
  logic       vld_p0;
  logic [BW:0]   beat_idx_q;
  logic [BW-1:0] cmp_sel;

  logic [NUM_PATTERNS-1:0] cmp_ok, beat_ok, len_ok, cfg_kill, flag_q, hit_p0;
  logic [CNT_WIDTH-1:0]    hit_cnt_q [NUM_PATTERNS];

  assign vld_p0 = mon_tvalid & mon_tready;

  // Pattern table: data/mask are plain storage, lengths are reset so a
  // freshly reset block can never hit.
  always_ff @(posedge clk) begin
    if (cfg_wr && (int'(cfg_idx) < NUM_PATTERNS) && (int'(cfg_beat) < MAX_BEATS)) begin
      tbl_data[cfg_idx][cfg_beat] <= cfg_data;
      tbl_mask[cfg_idx][cfg_beat] <= cfg_mask;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < NUM_PATTERNS; p++) tbl_len[p] <= '0;
    end else if (cfg_wr && (int'(cfg_idx) < NUM_PATTERNS)) begin
      tbl_len[cfg_idx] <= cfg_len;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (vld_p0) begin
      if (mon_tlast) begin
        state_nxt = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE:   state_nxt = ST_IN_PKT;
          ST_IN_PKT: if (beat_idx_q >= MAX_IDX) state_nxt = ST_OVERFLOW;
          default:   state_nxt = state_q;
        endcase
      end
    end
  end

  always_comb begin
    pkt_start = 1'b0;
    in_ovf    = 1'b0;
    unique case (state_q)
      ST_IDLE:     pkt_start = 1'b1;
      ST_OVERFLOW: in_ovf    = 1'b1;
      default:     ;
    endcase
  end

  // Beat index of the next accepted beat; parks at MAX_BEATS once exceeded.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_idx_q <= '0;
    end else if (vld_p0) begin
      if (mon_tlast)                 beat_idx_q <= '0;
      else if (beat_idx_q < MAX_IDX) beat_idx_q <= beat_idx_q + 1'b1;
    end
  end

  assign in_range = (beat_idx_q < MAX_IDX) & ~in_ovf;
  assign cmp_sel  = in_range ? beat_idx_q[BW-1:0] : '0;

  for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_pat
    beat_cmp #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
      .tdata    (mon_tdata),
      .tkeep    (mon_tkeep),
      .exp_data (tbl_data[p][cmp_sel]),
      .exp_mask (tbl_mask[p][cmp_sel]),
      .match    (cmp_ok[p])
    );
    assign hit_cnt[p*CNT_WIDTH +: CNT_WIDTH] = hit_cnt_q[p];
  end

  // Stage p0: per-pattern verdict for the beat accepted this cycle.
  always_comb begin
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      cfg_kill[p] = cfg_wr && (cfg_idx == IW'(p));
      beat_ok[p]  = (pkt_start | flag_q[p]) & cmp_ok[p] & in_range & ~cfg_kill[p];
      len_ok[p]   = (tbl_len[p] == beat_idx_q + 1'b1);
      hit_p0[p]   = vld_p0 & mon_tlast & arm & beat_ok[p] & len_ok[p];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      flag_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        if (vld_p0)           flag_q[p] <= mon_tlast ? 1'b0 : beat_ok[p];
        else if (cfg_kill[p]) flag_q[p] <= 1'b0;
      end
    end
  end

  // Stage p1: registered hit pulse and saturating counters.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      hit     <= '0;
      pkt_cnt <= '0;
      for (int p = 0; p < NUM_PATTERNS; p++) hit_cnt_q[p] <= '0;
    end else begin
      hit <= hit_p0;
      if (vld_p0 && mon_tlast)
        pkt_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(pkt_cnt), CNT_WIDTH));
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        if (hit_p0[p])
          hit_cnt_q[p] <= CNT_WIDTH'(sat_inc(SAT_W'(hit_cnt_q[p]), CNT_WIDTH));
      end
    end
  end

`ifdef AXIS_PKT_MATCHER_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]           to_cnt_q [NUM_PATTERNS];
  logic [NUM_PATTERNS-1:0] done_q, timeout_q;

  // Watchdog runs per pattern while armed until that pattern first hits;
  // a hit on the expiring cycle suppresses the timeout.
  always_ff @(posedge clk or posedge areset) begin
    if (areset || !arm) begin
      done_q    <= '0;
      timeout_q <= '0;
      for (int p = 0; p < NUM_PATTERNS; p++) to_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        if (hit_p0[p]) begin
          done_q[p] <= 1'b1;
        end else if (!done_q[p]) begin
          if (to_cnt_q[p] != TO_MAX)  to_cnt_q[p]  <= to_cnt_q[p] + 1'b1;
          if (to_cnt_q[p] == TO_LAST) timeout_q[p] <= 1'b1;
        end
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_matcher.sv
// Directed bench for axis_pkt_matcher: vector table of single-beat packets
// plus hand-written multi-beat, backpressure, overflow, reset and timeout cases.
module tb_axis_pkt_matcher;

  localparam int DW = 64;
  localparam int NP = 2;
  localparam int MB = 4;
  localparam int CW = 4;
  localparam int TO = 50;
  localparam int IW = 1;
  localparam int BW = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [63:0] D0   = 64'h0123_4567_1a00_4c4d;
  localparam logic [63:0] D1   = 64'hff23_4567_1a00_4c4d;
  localparam logic [63:0] D2   = 64'h5555_aaaa_0000_ffff;
  localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;
  localparam logic [63:0] NOB7 = 64'h00ff_ffff_ffff_ffff;

  logic clk = 1'b0;
  logic areset, arm, cfg_wr;
  logic [IW-1:0] cfg_idx;
  logic [BW-1:0] cfg_beat;
  logic [BW:0]   cfg_len;
  logic [DW-1:0] cfg_data, cfg_mask, mon_tdata;
  logic [DW/8-1:0] mon_tkeep;
  logic mon_tvalid, mon_tready, mon_tlast;
  logic [NP-1:0] hit, timeout;
  logic [NP*CW-1:0] hit_cnt;
  logic [CW-1:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_matcher #(
    .DATA_WIDTH(DW), .NUM_PATTERNS(NP), .MAX_BEATS(MB),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .areset(areset), .arm(arm), .cfg_wr(cfg_wr),
    .cfg_idx(cfg_idx), .cfg_beat(cfg_beat), .cfg_len(cfg_len),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .hit(hit), .hit_cnt(hit_cnt), .pkt_cnt(pkt_cnt), .timeout(timeout)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_pkt = 0;
  int exp_hc[NP];

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        arm;
    logic [1:0]  exp_hit;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic cfg_write(input int idx, input int beat, input int len,
                           input logic [63:0] data, input logic [63:0] mask);
    cfg_wr = 1'b1; cfg_idx = IW'(idx); cfg_beat = BW'(beat); cfg_len = (BW+1)'(len);
    cfg_data = data; cfg_mask = mask;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    mon_tdata = data; mon_tkeep = keep; mon_tlast = last;
    mon_tvalid = 1'b1; mon_tready = 1'b1;
    tick();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
  endtask

  // Called right after the tlast beat's edge: update model and check outputs.
  task automatic end_pkt(input string tag, input logic [1:0] exp_hit);
    exp_pkt = sat(exp_pkt);
    for (int p = 0; p < NP; p++) if (exp_hit[p]) exp_hc[p] = sat(exp_hc[p]);
    check({tag, ".hit"}, 64'(hit), 64'(exp_hit));
    check({tag, ".hit_cnt0"}, 64'(hit_cnt[0 +: CW]), 64'(exp_hc[0]));
    check({tag, ".hit_cnt1"}, 64'(hit_cnt[CW +: CW]), 64'(exp_hc[1]));
    check({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
    tick();
    check({tag, ".hit_fall"}, 64'(hit), 64'd0);
  endtask

  initial begin
    areset = 1'b1; arm = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_beat = '0; cfg_len = '0;
    cfg_data = '0; cfg_mask = '0; mon_tdata = '0; mon_tkeep = '0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    exp_hc[0] = 0; exp_hc[1] = 0;

    vecs[0] = '{D0,                    8'hff, 1'b1, 2'b11};
    vecs[1] = '{64'haa23_4567_1a00_4c4d, 8'hff, 1'b1, 2'b10};
    vecs[2] = '{64'h0123_4567_1a00_4c4e, 8'hff, 1'b1, 2'b00};
    vecs[3] = '{D0,                    8'h7f, 1'b1, 2'b10};
    vecs[4] = '{D0,                    8'hfe, 1'b1, 2'b00};
    vecs[5] = '{D0,                    8'hff, 1'b0, 2'b00};
    vecs[6] = '{D0,                    8'hff, 1'b1, 2'b11};

    repeat (3) tick();
    check("rst.hit", 64'(hit), 64'd0);
    check("rst.hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst.pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst.timeout", 64'(timeout), 64'd0);
    areset = 1'b0;
    tick();

    cfg_write(0, 0, 1, D0, ONES);
    cfg_write(1, 0, 1, D1, NOB7);

    for (int i = 0; i < 7; i++) begin
      arm = vecs[i].arm;
      send_beat(vecs[i].data, vecs[i].keep, 1'b1);
      end_pkt($sformatf("vec%0d", i), vecs[i].exp_hit);
    end
    arm = 1'b1;

    // Pattern 1 becomes two beats long; a one-beat packet only hits pattern 0.
    cfg_write(1, 0, 2, D1, NOB7);
    cfg_write(1, 1, 2, D2, ONES);
    send_beat(D0, 8'hff, 1'b1);
    end_pkt("len2_short", 2'b01);

    // Backpressure between the two beats.
    send_beat(D0, 8'hff, 1'b0);
    mon_tdata = D2; mon_tlast = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b0;
    repeat (3) tick();
    check("bp.stall_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("bp.stall_hit", 64'(hit), 64'd0);
    mon_tready = 1'b1;
    tick();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    end_pkt("bp", 2'b10);

    // Overflow: MAX_BEATS+1 beats, then a clean two-beat packet.
    send_beat(D0, 8'hff, 1'b0);
    for (int i = 0; i < MB - 1; i++) send_beat(D2, 8'hff, 1'b0);
    send_beat(D2, 8'hff, 1'b1);
    end_pkt("ovf", 2'b00);
    send_beat(D0, 8'hff, 1'b0);
    send_beat(D2, 8'hff, 1'b1);
    end_pkt("ovf_next", 2'b10);

    // A table write to pattern 1 mid-packet kills that packet's match.
    send_beat(D0, 8'hff, 1'b0);
    cfg_write(1, 1, 2, D2, ONES);
    send_beat(D2, 8'hff, 1'b1);
    end_pkt("cfg_mid", 2'b00);
    send_beat(D0, 8'hff, 1'b0);
    send_beat(D2, 8'hff, 1'b1);
    end_pkt("cfg_after", 2'b10);

    // Drive both counters into saturation.
    for (int i = 0; i < 13; i++) begin
      send_beat(D0, 8'hff, 1'b1);
      end_pkt($sformatf("sat%0d", i), 2'b01);
    end

    // Asynchronous reset with a packet in flight.
    send_beat(D0, 8'hff, 1'b0);
    #2 areset = 1'b1;
    #1;
    check("arst.pkt_cnt_async", 64'(pkt_cnt), 64'd0);
    check("arst.hit_cnt_async", 64'(hit_cnt), 64'd0);
    tick();
    areset = 1'b0;
    exp_pkt = 0; exp_hc[0] = 0; exp_hc[1] = 0;
    send_beat(D0, 8'hff, 1'b1);
    end_pkt("arst_len0", 2'b00);
    cfg_write(0, 0, 1, D0, ONES);
    send_beat(D0, 8'hff, 1'b1);
    end_pkt("arst_recfg", 2'b01);

    // Watchdog: armed with no traffic from a cleared state.
    arm = 1'b0;
    tick();
    check("to.cleared", 64'(timeout), 64'd0);
    arm = 1'b1;
    repeat (TO - 1) tick();
    check("to.before", 64'(timeout), 64'd0);
    tick();
`ifdef AXIS_PKT_MATCHER_TIMEOUT_EN
    check("to.at", 64'(timeout), 64'b11);
`else
    check("to.at", 64'(timeout), 64'd0);
`endif
    arm = 1'b0;
    tick();
    check("to.disarm", 64'(timeout), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
